// File: rtl/sr_cmd_debounce_pkg.sv
// Shared definitions for the SR command debouncer: arbitration FSM encoding
// and the saturating conflict counter.
package sr_cmd_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sr_debounce_ch.sv
// One request channel: two-flop synchroniser, debounce counter and a sticky
// pending bit raised on each debounced rising edge.
module sr_debounce_ch #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_clr_pend,
    output logic o_pending
);

    localparam int             CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_pend;
    logic          w_flip;
    logic          w_rise;

    // The level flips once the counter has seen DB_CYCLES differing samples
    // and the input still disagrees on the next one.
    assign w_flip = (r_sync2 != r_level) && (r_cnt == CNT_LAST);
    assign w_rise = w_flip && r_sync2;

    // Synchroniser, debounce counter, debounced level and pending request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (w_flip) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (r_sync2 != r_level) begin
                r_cnt   <= r_cnt + CW'(1);
            end else begin
                r_cnt   <= '0;
            end
            // A fresh rising edge outranks a clear issued in the same cycle.
            if (w_rise) begin
                r_pend <= 1'b1;
            end else if (i_clr_pend) begin
                r_pend <= 1'b0;
            end else begin
                r_pend <= r_pend;
            end
        end
    end

    assign o_pending = r_pend;

endmodule

// File: rtl/sr_cmd_debounce.sv
// Drives the s/r inputs of an SR flip-flop from two bouncy buttons: mutually
// exclusive one-cycle pulses with forced idle spacing, state mirror and conflict count.
module sr_cmd_debounce
    import sr_cmd_debounce_pkg::*;
#(
    parameter int DB_CYCLES  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int SET_WINS   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_in,
    input  logic             clr_in,
    output logic             s,
    output logic             r,
    output logic             q_mirror,
    output logic             busy,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e           r_state, w_state_nxt;
    logic             r_s, r_r, w_s_nxt, w_r_nxt;
    logic             r_q, r_busy;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [GW-1:0]    r_gap_cnt, w_gap_nxt;
    logic             w_set_pend, w_clr_pend;
    logic             w_take_set, w_take_clr;
    logic             w_serve;

    sr_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_set_ch (
        .clk        (clk),
        .rst        (rst),
        .i_raw      (set_in),
        .i_clr_pend (w_take_set),
        .o_pending  (w_set_pend)
    );

    sr_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_clr_ch (
        .clk        (clk),
        .rst        (rst),
        .i_raw      (clr_in),
        .i_clr_pend (w_take_clr),
        .o_pending  (w_clr_pend)
    );

    // Next-state logic; the last GAP cycle arbitrates exactly like IDLE so that
    // pulses are spaced by precisely GAP_CYCLES idle cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = 1'b0;
        w_r_nxt     = 1'b0;
        w_take_set  = 1'b0;
        w_take_clr  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_serve     = 1'b0;
        case (r_state)
            ST_IDLE: w_serve = 1'b1;
            ST_PULSE: begin
                if (GAP_CYCLES > 0) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = '0;
                end else begin
                    w_serve     = 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_serve   = 1'b1;
                end else begin
                    w_gap_nxt = r_gap_cnt + GW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_serve) begin
            w_state_nxt = ST_PULSE;
            if (w_set_pend && w_clr_pend) begin
                w_take_set = 1'b1;
                w_take_clr = 1'b1;
                w_cnt_nxt  = sat_inc(r_cnt);
                if (SET_WINS != 0) begin
                    w_s_nxt = 1'b1;
                end else begin
                    w_r_nxt = 1'b1;
                end
            end else if (w_set_pend) begin
                w_take_set = 1'b1;
                w_s_nxt    = 1'b1;
            end else if (w_clr_pend) begin
                w_take_clr = 1'b1;
                w_r_nxt    = 1'b1;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            w_take_set = 1'b0;
        end
    end

    // State, registered outputs, mirror and conflict counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_q       <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_s       <= w_s_nxt;
            r_r       <= w_r_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_cnt     <= w_cnt_nxt;
            r_gap_cnt <= w_gap_nxt;
            if (r_state == ST_PULSE && r_s) begin
                r_q <= 1'b1;
            end else if (r_state == ST_PULSE && r_r) begin
                r_q <= 1'b0;
            end else begin
                r_q <= r_q;
            end
        end
    end

    assign s            = r_s;
    assign r            = r_r;
    assign q_mirror     = r_q;
    assign busy         = r_busy;
    assign conflict_cnt = r_cnt;

endmodule
